// File: rtl/fsk_frame_mod.sv
// 2-FSK frame modulator: MSB-first, CYC_PER_BIT cycles per symbol, registered fsk_out one cycle after accept.
// in_ready only in IDLE or on a frame's last cycle (zero-gap back-to-back); FSK_PHASE_CONT_EN selects continuous phase.
module fsk_frame_mod #(
  parameter int DATA_W      = 16,
  parameter int CYC_PER_BIT = 16,
  parameter int DIV_HI      = 1,
  parameter int DIV_LO      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              fsk_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int SYM_W = $clog2(CYC_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int RUN_W = $clog2(DIV_LO);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(CYC_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [SYM_W-1:0]  sym_cnt, sym_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt;
  logic              tone, tone_nxt;

  logic              sym_last;
  logic              last_cyc;
  logic              accept;
  logic              tone_wrap;
  int                div_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      sym_cnt <= '0;
      run_cnt <= '0;
      tone    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_nxt;
      sym_cnt <= sym_nxt;
      run_cnt <= run_nxt;
      tone    <= tone_nxt;
    end
  end

  always_comb begin
    sym_last  = (sym_cnt == SYM_LAST);
    last_cyc  = (state == SEND) && (bit_cnt == '0) && sym_last;
    in_ready  = !rst && ((state == IDLE) || last_cyc);
    accept    = in_valid && in_ready;
    // tone half-period follows the bit currently on the line
    div_cur   = shreg[DATA_W-1] ? DIV_HI : DIV_LO;
    tone_wrap = (int'(run_cnt) + 1) >= div_cur;

    state_nxt = state;
    shreg_nxt = shreg;
    bit_nxt   = bit_cnt;
    sym_nxt   = sym_cnt;
    run_nxt   = run_cnt;
    tone_nxt  = tone;

    case (state)
      IDLE: begin
        tone_nxt = 1'b0;
        run_nxt  = '0;
        if (accept) begin
          state_nxt = SEND;
          shreg_nxt = in_data;
          bit_nxt   = BIT_TOP;
          sym_nxt   = '0;
        end
      end
      SEND: begin
        sym_nxt  = sym_cnt + SYM_W'(1);
        tone_nxt = tone_wrap ? ~tone : tone;
        run_nxt  = tone_wrap ? '0 : run_cnt + RUN_W'(1);
        if (sym_last) begin
          sym_nxt = '0;
`ifdef FSK_PHASE_CONT_EN
          // level and run count carry across the symbol boundary
`else
          tone_nxt = 1'b0;
          run_nxt  = '0;
`endif
          if (bit_cnt == '0) begin
            if (accept) begin
              shreg_nxt = in_data;
              bit_nxt   = BIT_TOP;
            end else begin
              state_nxt = IDLE;
              tone_nxt  = 1'b0;
              run_nxt   = '0;
            end
          end else begin
            shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
            bit_nxt   = bit_cnt - BIT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fsk_out    = tone;
  assign busy       = (state == SEND);
  assign frame_done = last_cyc && !rst;

endmodule
